// File: rtl/program_mem_arbiter.sv
// program_mem_arbiter: round-robin share of one program-memory read port
// among NUM_REQ instruction fetchers.
// Optional feature macro: PMA_LAST_FETCH_BYPASS_EN (last-fetch bypass buffer).
module program_mem_arbiter #(
  parameter int NUM_REQ               = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQ-1:0]                       req_read_valid,
  input  logic [NUM_REQ*PROGRAM_MEM_ADDR_BITS-1:0] req_read_address,
  output logic [NUM_REQ-1:0]                       req_read_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0]         req_read_data,
  output logic                                     program_mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]         program_mem_read_address,
  input  logic                                     program_mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0]         program_mem_read_data,
  output logic                                     busy
);

  localparam int AW  = PROGRAM_MEM_ADDR_BITS;
  localparam int DW  = PROGRAM_MEM_DATA_BITS;
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESPOND} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic [IDW-1:0]       rr_last_q, rr_last_d;
  logic                 mask_vld_q, mask_vld_d;
  logic [IDW-1:0]       mask_id_q, mask_id_d;
  logic                 mem_vld_q, mem_vld_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [NUM_REQ-1:0]   rdy_q, rdy_d;
  logic [DW-1:0]        data_q, data_d;

  logic [NUM_REQ-1:0]   eligible;
  logic                 win_found;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       cand;
  int unsigned          idx;
  logic [AW-1:0]        win_addr;
  logic                 bypass_hit;
  logic [DW-1:0]        bypass_data;

`ifdef PMA_LAST_FETCH_BYPASS_EN
  logic                 last_vld_q, last_vld_d;
  logic [AW-1:0]        last_addr_q, last_addr_d;
  logic [DW-1:0]        last_data_q, last_data_d;
`endif

  // Eligibility: drop the requester just served for one IDLE cycle (stale valid).
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_read_valid[i] & ~(mask_vld_q & (mask_id_q == IDW'(i)));
    end
  end

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(rr_last_q) + k) % NUM_REQ;
      cand = IDW'(idx);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        winner    = cand;
      end
    end
  end

  // Address of the winning requester.
  always_comb begin
    win_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == winner) win_addr = req_read_address[i*AW +: AW];
    end
  end

`ifdef PMA_LAST_FETCH_BYPASS_EN
  // Bypass hit when the winner asks for the most recently fetched address.
  always_comb begin
    bypass_hit  = last_vld_q && (win_addr == last_addr_q);
    bypass_data = last_data_q;
  end
`else
  // No bypass storage: every grant goes to memory.
  always_comb begin
    bypass_hit  = 1'b0;
    bypass_data = '0;
  end
`endif

  // Next-state and registered-output logic for the IDLE/ISSUE/RESPOND FSM.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_last_d  = rr_last_q;
    mask_vld_d = mask_vld_q;
    mask_id_d  = mask_id_q;
    mem_vld_d  = mem_vld_q;
    mem_addr_d = mem_addr_q;
    rdy_d      = rdy_q;
    data_d     = data_q;
`ifdef PMA_LAST_FETCH_BYPASS_EN
    last_vld_d  = last_vld_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        mask_vld_d = 1'b0;
        if (win_found) begin
          grant_id_d = winner;
          rr_last_d  = winner;
          if (bypass_hit) begin
            data_d        = bypass_data;
            rdy_d         = '0;
            rdy_d[winner] = 1'b1;
            state_d       = S_RESPOND;
          end else begin
            mem_vld_d  = 1'b1;
            mem_addr_d = win_addr;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (program_mem_read_ready) begin
          data_d            = program_mem_read_data;
          rdy_d             = '0;
          rdy_d[grant_id_q] = 1'b1;
          mem_vld_d         = 1'b0;
          state_d           = S_RESPOND;
`ifdef PMA_LAST_FETCH_BYPASS_EN
          last_vld_d  = 1'b1;
          last_addr_d = mem_addr_q;
          last_data_d = program_mem_read_data;
`endif
        end
      end
      S_RESPOND: begin
        rdy_d      = '0;
        mask_vld_d = 1'b1;
        mask_id_d  = grant_id_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_id_q <= '0;
      rr_last_q  <= IDW'(NUM_REQ - 1);
      mask_vld_q <= 1'b0;
      mask_id_q  <= '0;
      mem_vld_q  <= 1'b0;
      mem_addr_q <= '0;
      rdy_q      <= '0;
      data_q     <= '0;
`ifdef PMA_LAST_FETCH_BYPASS_EN
      last_vld_q  <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_last_q  <= rr_last_d;
      mask_vld_q <= mask_vld_d;
      mask_id_q  <= mask_id_d;
      mem_vld_q  <= mem_vld_d;
      mem_addr_q <= mem_addr_d;
      rdy_q      <= rdy_d;
      data_q     <= data_d;
`ifdef PMA_LAST_FETCH_BYPASS_EN
      last_vld_q  <= last_vld_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
`endif
    end
  end

  assign req_read_ready           = rdy_q;
  assign req_read_data            = data_q;
  assign program_mem_read_valid   = mem_vld_q;
  assign program_mem_read_address = mem_addr_q;
  assign busy                     = (state_q != S_IDLE);

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Scoreboard bench for program_mem_arbiter: directed requests push expected
// responses and memory addresses; a negedge monitor pops and compares.
module tb_program_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_read_ready;
  logic [15:0] req_read_data;
  logic        mem_valid;
  logic [7:0]  mem_addr;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_data = '0;
  logic        busy;

  program_mem_arbiter #(
    .NUM_REQ(4),
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_read_valid(req_valid),
    .req_read_address(req_addr),
    .req_read_ready(req_read_ready),
    .req_read_data(req_read_data),
    .program_mem_read_valid(mem_valid),
    .program_mem_read_address(mem_addr),
    .program_mem_read_ready(mem_ready),
    .program_mem_read_data(mem_data),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rdy;
    logic [15:0] data;
  } rsp_t;

  rsp_t       exp_rsp_q[$];
  logic [7:0] exp_addr_q[$];
  int         pulse_t[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         mem_wait = 1;
  bit         mem_hold = 1'b0;
  int         mem_cnt = 0;
  int         mem_acc = 0;
  logic [3:0] pend1 = '0;
  logic [3:0] pend2 = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_fn(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  task automatic exp_rsp(input logic [3:0] r, input logic [15:0] d);
    rsp_t e;
    e.rdy  = r;
    e.data = d;
    exp_rsp_q.push_back(e);
  endtask

  // One clock: fetchers drop valid one cycle after seeing ready; memory answers after mem_wait cycles.
  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~pend2;
    pend2 = pend1;
    pend1 = req_read_ready;
    if (mem_ready) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else if (mem_valid && !mem_hold) begin
      if (mem_cnt >= mem_wait) begin
        mem_ready = 1'b1;
        mem_data  = mem_fn(mem_addr);
        mem_acc++;
      end else begin
        mem_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    mem_ready = 1'b0;
    mem_cnt   = 0;
    mem_hold  = 1'b0;
    step();
    step();
    reset = 1'b0;
    pend1 = '0;
    pend2 = '0;
    mem_acc = 0;
    exp_rsp_q.delete();
    exp_addr_q.delete();
    pulse_t.delete();
    chk("rst_ready", req_read_ready, 0);
    chk("rst_data", req_read_data, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_addr_q.size() != 0) && n < maxc) begin
      step();
      n++;
    end
    chk({name, "_drained"}, exp_rsp_q.size() + exp_addr_q.size(), 0);
    repeat (6) step();
  endtask

  // Monitor: compares memory address and response pulses against the queues.
  initial begin
    logic [3:0] prev;
    rsp_t       e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_valid) begin
          chk("mem_valid_with_ready_pulse", req_read_ready, 0);
          if (exp_addr_q.size() == 0) chk("mem_valid_unexpected", mem_valid, 0);
          else begin
            chk("mem_addr", mem_addr, exp_addr_q[0]);
            if (mem_ready) void'(exp_addr_q.pop_front());
          end
        end
        if (req_read_ready != 0) begin
          chk("ready_onehot", $onehot(req_read_ready), 1);
          chk("ready_pulse_width", prev, 0);
          chk("busy_in_respond", busy, 1);
          pulse_t.push_back(cyc);
          if (exp_rsp_q.size() == 0) chk("ready_unexpected", req_read_ready, 0);
          else begin
            e = exp_rsp_q.pop_front();
            chk("ready_vec", req_read_ready, e.rdy);
            chk("ready_data", req_read_data, e.data);
          end
        end
        prev = req_read_ready;
      end else begin
        prev = '0;
      end
    end
  end

  initial begin
    int n;
    // Test 1: all four request, round-robin 0,1,2,3 then 0 again.
    do_reset();
    mem_wait  = 1;
    req_addr  = {8'h04, 8'h03, 8'h02, 8'h01};
    req_valid = 4'b1111;
    exp_addr_q.push_back(8'h01); exp_rsp_q.push_back('{4'b0001, 16'h01FE});
    exp_addr_q.push_back(8'h02); exp_rsp_q.push_back('{4'b0010, 16'h02FD});
    exp_addr_q.push_back(8'h03); exp_rsp_q.push_back('{4'b0100, 16'h03FC});
    exp_addr_q.push_back(8'h04); exp_rsp_q.push_back('{4'b1000, 16'h04FB});
    exp_addr_q.push_back(8'h11); exp_rsp_q.push_back('{4'b0001, 16'h11EE});
    n = 0;
    while (req_valid[0] && n < 50) begin step(); n++; end
    chk("t1_req0_served", req_valid[0], 0);
    req_addr[7:0] = 8'h11;
    req_valid[0]  = 1'b1;
    drain("t1", 100);

    // Test 2: single requester 2, three wait cycles, no stale re-grant.
    do_reset();
    mem_wait = 3;
    req_addr[23:16] = 8'h10;
    req_valid = 4'b0100;
    exp_addr_q.push_back(8'h10);
    exp_rsp(4'b0100, 16'hBEEF);
    drain("t2", 50);
    chk("t2_mem_accesses", mem_acc, 1);

    // Test 3: after requester 1 is served, 3 beats 1 at the next IDLE.
    do_reset();
    mem_wait = 0;
    req_addr[15:8] = 8'h21;
    req_valid = 4'b0010;
    exp_addr_q.push_back(8'h21); exp_rsp(4'b0010, 16'h21DE);
    exp_addr_q.push_back(8'h23); exp_rsp(4'b1000, 16'h23DC);
    exp_addr_q.push_back(8'h22); exp_rsp(4'b0010, 16'h22DD);
    n = 0;
    while (req_valid[1] && n < 50) begin step(); n++; end
    chk("t3_req1_served", req_valid[1], 0);
    req_addr[15:8]  = 8'h22;
    req_addr[31:24] = 8'h23;
    req_valid = 4'b1010;
    drain("t3", 50);

    // Test 4: reset during ISSUE, late memory ready ignored, rr pointer restarts.
    do_reset();
    mem_hold = 1'b1;
    req_addr[7:0] = 8'h40;
    req_valid = 4'b0001;
    exp_addr_q.push_back(8'h40);
    n = 0;
    while (!mem_valid && n < 10) begin step(); n++; end
    chk("t4_issue_reached", mem_valid, 1);
    step();
    step();
    reset = 1'b1;
    req_valid = '0;
    step();
    chk("t4_rst_mem_valid", mem_valid, 0);
    chk("t4_rst_mem_addr", mem_addr, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ready", req_read_ready, 0);
    reset = 1'b0;
    exp_addr_q.delete();
    pend1 = '0;
    pend2 = '0;
    mem_hold  = 1'b0;
    mem_cnt   = 0;
    mem_ready = 1'b1;
    mem_data  = 16'hDEAD;
    repeat (5) step();
    chk("t4_late_ready_ignored", req_read_ready, 0);
    chk("t4_idle_after_late_ready", busy, 0);
    mem_wait = 1;
    req_addr[7:0]   = 8'h41;
    req_addr[23:16] = 8'h42;
    req_valid = 4'b0101;
    exp_addr_q.push_back(8'h41); exp_rsp(4'b0001, 16'h41BE);
    exp_addr_q.push_back(8'h42); exp_rsp(4'b0100, 16'h42BD);
    drain("t4", 50);

    // Test 5: requester address changes during ISSUE; memory address stays latched.
    do_reset();
    mem_wait = 3;
    req_addr[15:8] = 8'h20;
    req_valid = 4'b0010;
    exp_addr_q.push_back(8'h20);
    exp_rsp(4'b0010, 16'h20DF);
    n = 0;
    while (!mem_valid && n < 10) begin step(); n++; end
    chk("t5_issue_reached", mem_valid, 1);
    req_addr[15:8] = 8'h30;
    drain("t5", 50);

    // Test 6: two requesters fetch the same address back to back.
    do_reset();
    mem_wait = 0;
    req_addr[7:0]  = 8'h05;
    req_addr[15:8] = 8'h05;
    req_valid = 4'b0011;
    exp_addr_q.push_back(8'h05);
`ifndef PMA_LAST_FETCH_BYPASS_EN
    exp_addr_q.push_back(8'h05);
`endif
    exp_rsp(4'b0001, 16'h05FA);
    exp_rsp(4'b0010, 16'h05FA);
    drain("t6", 50);
`ifdef PMA_LAST_FETCH_BYPASS_EN
    chk("t6_mem_accesses", mem_acc, 1);
`else
    chk("t6_mem_accesses", mem_acc, 2);
`endif
    chk("t6_pulse_count", pulse_t.size(), 2);
    if (pulse_t.size() == 2) begin
`ifdef PMA_LAST_FETCH_BYPASS_EN
      chk("t6_pulse_gap", pulse_t[1] - pulse_t[0], 2);
`else
      chk("t6_pulse_gap", pulse_t[1] - pulse_t[0], 3);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
